// File: rtl/vpu_reduction_sequencer.sv
// vpu_reduction_sequencer: splits one vector reduction request into
// EXEC_CNT chunks, feeds them to the reduction unit, returns lane 0.

module vpu_reduction_sequencer #(
    parameter int OPERAND_WIDTH    = 16,
    parameter int ELEM_PER_DIM_CNT = 64,
    parameter int EXEC_CNT         = 4,
    parameter int TIMEOUT_CYCLES   = 255,
    localparam int CHUNK_W = (ELEM_PER_DIM_CNT / EXEC_CNT) * OPERAND_WIDTH,
    localparam int VEC_W   = ELEM_PER_DIM_CNT * OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [VEC_W-1:0]         req_vec_i,
    output logic                     ru_start_o,
    output logic                     ru_sum_o,
    output logic                     ru_max_o,
    output logic [CHUNK_W-1:0]       ru_operand_o,
    input  logic [CHUNK_W-1:0]       ru_dout_i,
    input  logic                     ru_done_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0] rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    localparam int CIDX_W = $clog2(EXEC_CNT);
    localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(EXEC_CNT - 1);
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                   state_q;
    logic                     req_ready_q;
    logic                     busy_q;
    logic                     ru_start_q;
    logic                     ru_sum_q;
    logic                     ru_max_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic [OPERAND_WIDTH-1:0] rsp_data_q;
    logic [VEC_W-1:0]         vec_q;
    logic [CHUNK_W-1:0]       ru_operand_q;
    logic [CIDX_W-1:0]        chunk_q;
    logic [CIDX_W-1:0]        chunk_d;
    logic [15:0]              wdog_q;
    logic [15:0]              wdog_d;
    logic [CHUNK_W-1:0]       chunk_w [EXEC_CNT];
    logic                     accept_w;
    logic                     op_legal_w;
    logic                     unused_dout_w;

    for (genvar g = 0; g < EXEC_CNT; g++) begin : g_chunk
        assign chunk_w[g] = vec_q[g*CHUNK_W +: CHUNK_W];
    end

    assign chunk_d       = chunk_q + 1'b1;
    assign wdog_d        = wdog_q + 16'd1;
    assign accept_w      = req_valid_i && req_ready_q;
    assign op_legal_w    = (req_op_i == 2'b01) || (req_op_i == 2'b10);
    assign unused_dout_w = ^ru_dout_i[CHUNK_W-1:OPERAND_WIDTH];

    // Sequencer FSM; every output is a register updated with the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            ru_start_q   <= 1'b0;
            ru_sum_q     <= 1'b0;
            ru_max_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            vec_q        <= '0;
            ru_operand_q <= '0;
            chunk_q      <= '0;
            wdog_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        vec_q        <= req_vec_i;
                        ru_operand_q <= req_vec_i[CHUNK_W-1:0];
                        chunk_q      <= '0;
                        wdog_q       <= '0;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (op_legal_w) begin
                            ru_sum_q   <= req_op_i[0];
                            ru_max_q   <= req_op_i[1];
                            ru_start_q <= 1'b1;
                            state_q    <= ISSUE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    ru_start_q <= 1'b0;
                    wdog_q     <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (ru_done_i) begin
                        if (chunk_q == LAST_CHUNK) begin
                            rsp_data_q  <= ru_dout_i[OPERAND_WIDTH-1:0];
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            chunk_q      <= chunk_d;
                            ru_operand_q <= chunk_w[chunk_d];
                            ru_start_q   <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end else begin
                        wdog_q <= wdog_d;
                        if (wdog_d == WDOG_LIMIT) begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        ru_sum_q    <= 1'b0;
                        ru_max_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    ru_start_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign busy_o       = busy_q;
    assign ru_start_o   = ru_start_q;
    assign ru_sum_o     = ru_sum_q;
    assign ru_max_o     = ru_max_q;
    assign ru_operand_o = ru_operand_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_data_o   = rsp_data_q;

endmodule

// File: tb/tb_vpu_reduction_sequencer.sv
// tb_vpu_reduction_sequencer: randomized and directed checks of the
// reduction sequencer against a model reduction unit and a vector reference.

module tb_vpu_reduction_sequencer;

    localparam int OW  = 16;
    localparam int EPD = 64;
    localparam int EC  = 4;
    localparam int TO  = 8;
    localparam int CW  = (EPD / EC) * OW;
    localparam int VW  = EPD * OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'b00;
    logic [VW-1:0] req_vec_i = '0;
    logic          ru_start_o;
    logic          ru_sum_o;
    logic          ru_max_o;
    logic [CW-1:0] ru_operand_o;
    logic [CW-1:0] ru_dout_i;
    logic          ru_done_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [OW-1:0] rsp_data_o;
    logic          rsp_err_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model reduction unit controls
    int          lat = 3;
    bit          withhold = 0;
    bit          fixed_mode = 0;
    logic [15:0] fixed_val = 16'h0;
    int          cnt = 0;
    logic [15:0] acc = 16'h0;
    logic [CW-1:0] cur_opnd;
    logic        cur_max;
    int          st_cyc[$];
    logic [CW-1:0] st_opnd[$];
    logic        st_sum[$];
    logic        st_max[$];

    vpu_reduction_sequencer #(
        .OPERAND_WIDTH(OW),
        .ELEM_PER_DIM_CNT(EPD),
        .EXEC_CNT(EC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_op_i(req_op_i),
        .req_vec_i(req_vec_i),
        .ru_start_o(ru_start_o),
        .ru_sum_o(ru_sum_o),
        .ru_max_o(ru_max_o),
        .ru_operand_o(ru_operand_o),
        .ru_dout_i(ru_dout_i),
        .ru_done_i(ru_done_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] rand_chunk();
        logic [CW-1:0] c;
        for (int i = 0; i < CW / 32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Whole-vector reference: wrapping sum or unsigned max of all elements.
    function automatic logic [15:0] ref_reduce(input logic [1:0] op, input logic [VW-1:0] v);
        logic [15:0] r;
        logic [15:0] e;
        r = 16'h0;
        for (int k = 0; k < EPD; k++) begin
            e = v[k*OW +: OW];
            if (op == 2'b01) r = r + e;
            else if (e > r) r = e;
        end
        return r;
    endfunction

    function automatic logic [15:0] chunk_reduce(input logic [CW-1:0] c, input logic is_max);
        logic [15:0] r;
        logic [15:0] e;
        r = 16'h0;
        for (int k = 0; k < CW / OW; k++) begin
            e = c[k*OW +: OW];
            if (!is_max) r = r + e;
            else if (e > r) r = e;
        end
        return r;
    endfunction

    // Model reduction unit: done L cycles after start, accumulating lane 0.
    initial begin
        logic [15:0] r;
        ru_done_i = 1'b0;
        ru_dout_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ru_done_i = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        r = chunk_reduce(cur_opnd, cur_max);
                        if (st_cyc.size() == 1) acc = r;
                        else if (cur_max) acc = (r > acc) ? r : acc;
                        else acc = acc + r;
                        ru_dout_i = rand_chunk();
                        ru_dout_i[15:0] = fixed_mode ? fixed_val : acc;
                        ru_done_i = 1'b1;
                    end
                end
                if (ru_start_o === 1'b1) begin
                    st_cyc.push_back(cyc);
                    st_opnd.push_back(ru_operand_o);
                    st_sum.push_back(ru_sum_o);
                    st_max.push_back(ru_max_o);
                    cur_opnd = ru_operand_o;
                    cur_max = ru_max_o;
                    if (!withhold) cnt = lat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // Issue one request and follow it through the response handshake.
    task automatic do_request(input bit sync, input logic [1:0] op, input logic [VW-1:0] v,
                              input int hold, output logic [15:0] data, output logic err,
                              output int latency, output bit resp_ok, output bit sm_ok,
                              output logic sum0, output logic max0);
        int t0;
        int guard;
        st_cyc.delete();
        st_opnd.delete();
        st_sum.delete();
        st_max.delete();
        if (sync) @(negedge clk);
        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid_i = 1'b1;
        req_op_i = op;
        req_vec_i = v;
        t0 = cyc;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_vec_i = rand_vec();
        req_op_i = 2'($urandom);
        sum0 = ru_sum_o;
        max0 = ru_max_o;
        sm_ok = 1;
        guard = 0;
        while (rsp_valid_o !== 1'b1 && guard < 2000) begin
            if (ru_sum_o !== sum0 || ru_max_o !== max0) sm_ok = 0;
            @(negedge clk);
            guard++;
        end
        latency = cyc - t0;
        data = rsp_data_o;
        err = rsp_err_o;
        resp_ok = (rsp_valid_o === 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== data || rsp_err_o !== err ||
                req_ready_o !== 1'b0 || busy_o !== 1'b1 ||
                ru_sum_o !== sum0 || ru_max_o !== max0) resp_ok = 0;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            ru_sum_o !== 1'b0 || ru_max_o !== 1'b0) resp_ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready_o, busy_o, ru_start_o, ru_sum_o, ru_max_o, rsp_valid_o, rsp_err_o} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 1000000",
                     {req_ready_o, busy_o, ru_start_o, ru_sum_o, ru_max_o, rsp_valid_o, rsp_err_o});
        end
        n_checks++;
        if (rsp_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0000", rsp_data_o);
        end
        n_checks++;
        if (ru_operand_o !== '0) begin
            n_fail++;
            $display("FAIL reset_operand: got %h required 0", ru_operand_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b required ready=1 busy=0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_sum_directed();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        bit rok, smok;
        for (int k = 0; k < EPD; k++) v[k*OW +: OW] = 16'h3F80;
        lat = 3;
        fixed_mode = 1;
        fixed_val = 16'h4280;
        do_request(1, 2'b01, v, 0, data, err, latency, rok, smok, s0, m0);
        fixed_mode = 0;
        n_checks++;
        if (data !== 16'h4280 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL sum_result: got data=%h err=%b required data=4280 err=0", data, err);
        end
        n_checks++;
        if (latency !== 17) begin
            n_fail++;
            $display("FAIL sum_latency: got %0d required 17", latency);
        end
        n_checks++;
        if (st_cyc.size() !== EC) begin
            n_fail++;
            $display("FAIL sum_starts: got %0d required %0d", st_cyc.size(), EC);
        end
        for (int i = 1; i < st_cyc.size(); i++) begin
            n_checks++;
            if (st_cyc[i] - st_cyc[i-1] !== 4) begin
                n_fail++;
                $display("FAIL sum_spacing%0d: got %0d required 4", i, st_cyc[i] - st_cyc[i-1]);
            end
        end
        for (int i = 0; i < st_sum.size(); i++) begin
            n_checks++;
            if (st_sum[i] !== 1'b1 || st_max[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL sum_flags%0d: got sum=%b max=%b required sum=1 max=0", i, st_sum[i], st_max[i]);
            end
        end
        n_checks++;
        if (!rok || !smok) begin
            n_fail++;
            $display("FAIL sum_handshake: got resp_ok=%b hold_ok=%b required 1 1", rok, smok);
        end
    endtask

    task automatic test_max_directed();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        bit rok, smok;
        for (int k = 0; k < EPD; k++) v[k*OW +: OW] = 16'(k);
        lat = $urandom_range(1, 5);
        do_request(1, 2'b10, v, 0, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (data !== 16'h003F || data !== ref_reduce(2'b10, v) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL max_result: got data=%h err=%b required data=003f err=0", data, err);
        end
        n_checks++;
        if (m0 !== 1'b1 || s0 !== 1'b0 || !smok) begin
            n_fail++;
            $display("FAIL max_flags_held: got max=%b sum=%b held=%b required 1 0 1", m0, s0, smok);
        end
        n_checks++;
        if (st_opnd.size() !== EC) begin
            n_fail++;
            $display("FAIL max_starts: got %0d required %0d", st_opnd.size(), EC);
        end
        for (int i = 0; i < st_opnd.size() && i < EC; i++) begin
            n_checks++;
            if (st_opnd[i] !== v[i*CW +: CW] || st_max[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL max_chunk%0d: got first elem %h max=%b required %h max=1",
                         i, st_opnd[i][15:0], st_max[i], 16'(16*i));
            end
        end
        n_checks++;
        if (latency !== 1 + EC * (1 + lat)) begin
            n_fail++;
            $display("FAIL max_latency: got %0d required %0d", latency, 1 + EC * (1 + lat));
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        bit rok, smok;
        v = rand_vec();
        lat = 2;
        do_request(1, 2'b01, v, 10, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (!rok) begin
            n_fail++;
            $display("FAIL bp_stable: got resp_ok=0 required 1");
        end
        n_checks++;
        if (data !== ref_reduce(2'b01, v) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got %h err=%b required %h err=0", data, err, ref_reduce(2'b01, v));
        end
    endtask

    task automatic test_timeout();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        bit rok, smok;
        v = rand_vec();
        withhold = 1;
        do_request(1, 2'b01, v, 2, data, err, latency, rok, smok, s0, m0);
        withhold = 0;
        n_checks++;
        if (err !== 1'b1 || data !== 16'h0) begin
            n_fail++;
            $display("FAIL to_result: got err=%b data=%h required err=1 data=0000", err, data);
        end
        n_checks++;
        if (latency !== 2 + TO || st_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL to_latency: got %0d starts=%0d required %0d starts=1", latency, st_cyc.size(), 2 + TO);
        end
        n_checks++;
        if (!rok) begin
            n_fail++;
            $display("FAIL to_handshake: got 0 required 1");
        end
        lat = TO + 1;
        do_request(1, 2'b10, v, 0, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (err !== 1'b1 || data !== 16'h0 || latency !== 2 + TO) begin
            n_fail++;
            $display("FAIL to_late_done: got err=%b data=%h lat=%0d required err=1 data=0000 lat=%0d",
                     err, data, latency, 2 + TO);
        end
        lat = TO;
        v = rand_vec();
        do_request(1, 2'b01, v, 0, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (err !== 1'b0 || data !== ref_reduce(2'b01, v) || latency !== 1 + EC * (1 + TO)) begin
            n_fail++;
            $display("FAIL to_done_priority: got err=%b data=%h lat=%0d required err=0 data=%h lat=%0d",
                     err, data, latency, ref_reduce(2'b01, v), 1 + EC * (1 + TO));
        end
        lat = 3;
        v = rand_vec();
        do_request(1, 2'b10, v, 1, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (err !== 1'b0 || data !== ref_reduce(2'b10, v) || !rok) begin
            n_fail++;
            $display("FAIL to_recover: got err=%b data=%h required err=0 data=%h", err, data, ref_reduce(2'b10, v));
        end
    endtask

    task automatic test_illegal();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        bit rok, smok;
        logic [1:0] ops [2];
        ops[0] = 2'b11;
        ops[1] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            do_request(1, ops[i], v, 1, data, err, latency, rok, smok, s0, m0);
            n_checks++;
            if (err !== 1'b1 || data !== 16'h0 || latency !== 1) begin
                n_fail++;
                $display("FAIL illegal_%b: got err=%b data=%h lat=%0d required err=1 data=0000 lat=1",
                         ops[i], err, data, latency);
            end
            n_checks++;
            if (st_cyc.size() !== 0 || s0 !== 1'b0 || m0 !== 1'b0 || !rok) begin
                n_fail++;
                $display("FAIL illegal_quiet_%b: got starts=%0d sum=%b max=%b ok=%b required 0 0 0 1",
                         ops[i], st_cyc.size(), s0, m0, rok);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic err, s0, m0;
        int latency;
        int guard;
        bit rok, smok, quiet;
        st_cyc.delete();
        lat = 3;
        v = rand_vec();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i = 2'b01;
        req_vec_i = v;
        @(negedge clk);
        req_valid_i = 1'b0;
        guard = 0;
        while (st_cyc.size() < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1 || st_cyc.size() !== 3) begin
            n_fail++;
            $display("FAIL mid_inflight: got busy=%b starts=%0d required busy=1 starts=3", busy_o, st_cyc.size());
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_o, busy_o, ru_start_o, ru_sum_o, ru_max_o, rsp_valid_o, rsp_err_o} !== 7'b1000000 ||
            ru_operand_o !== '0 || rsp_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got flags=%b data=%h required 1000000 data=0000",
                     {req_ready_o, busy_o, ru_start_o, ru_sum_o, ru_max_o, rsp_valid_o, rsp_err_o}, rsp_data_o);
        end
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || ru_start_o !== 1'b0) quiet = 0;
        end
        rst_n = 1'b1;
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL mid_no_response: got activity during reset required none");
        end
        v = rand_vec();
        do_request(0, 2'b10, v, 0, data, err, latency, rok, smok, s0, m0);
        n_checks++;
        if (err !== 1'b0 || data !== ref_reduce(2'b10, v) || latency !== 1 + EC * (1 + lat)) begin
            n_fail++;
            $display("FAIL mid_fresh: got err=%b data=%h lat=%0d required err=0 data=%h lat=%0d",
                     err, data, latency, ref_reduce(2'b10, v), 1 + EC * (1 + lat));
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        logic [15:0] data;
        logic [15:0] expd;
        logic [1:0] op;
        logic err, s0, m0;
        int latency;
        int hold;
        bit rok, smok;
        for (int t = 0; t < 12; t++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            lat = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            v = rand_vec();
            expd = ref_reduce(op, v);
            do_request(1, op, v, hold, data, err, latency, rok, smok, s0, m0);
            n_checks++;
            if (data !== expd || err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_data: got %h err=%b required %h err=0", t, data, err, expd);
            end
            n_checks++;
            if (latency !== 1 + EC * (1 + lat) || st_cyc.size() !== EC) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: got lat=%0d starts=%0d required lat=%0d starts=%0d",
                         t, latency, st_cyc.size(), 1 + EC * (1 + lat), EC);
            end
            n_checks++;
            if (s0 !== op[0] || m0 !== op[1] || !smok || !rok) begin
                n_fail++;
                $display("FAIL rnd%0d_ctrl: got sum=%b max=%b held=%b ok=%b required %b %b 1 1",
                         t, s0, m0, smok, rok, op[0], op[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sum_directed();
        test_max_directed();
        test_backpressure();
        test_timeout();
        test_illegal();
        test_reset_midflight();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_reduction_sequencer.md
VPU_REDUCTION_SEQUENCER -- requirements
Module: VPU_REDUCTION_SEQUENCER

Interface
REQ-001 Parameters SHALL be:
- OPERAND_WIDTH, 16, element width in bits.
- ELEM_PER_DIM_CNT, 64, elements per request vector.
- EXEC_CNT, 4, number of chunks per vector. Must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 255, maximum wait per chunk. Range 1..65535.
REQ-002 Derived values SHALL be:
- CHUNK_W = (ELEM_PER_DIM_CNT/EXEC_CNT)*OPERAND_WIDTH, default 256.
- VEC_W = ELEM_PER_DIM_CNT*OPERAND_WIDTH.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  2  operation: 2'b01 = sum, 2'b10 = max, other values illegal.
- req_vec_i  in  VEC_W  full vector; element k is at bits [k*OPERAND_WIDTH +: OPERAND_WIDTH].
- ru_start_o  out  1  one-cycle start pulse to the reduction unit.
- ru_sum_o  out  1  reduction unit fp_sum_r.
- ru_max_o  out  1  reduction unit fp_max_r.
- ru_operand_o  out  CHUNK_W  current chunk.
- ru_dout_i  in  CHUNK_W  reduction unit result; the scalar is in lane 0.
- ru_done_i  in  1  reduction unit done pulse, one per chunk.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  OPERAND_WIDTH  reduced scalar.
- rsp_err_o  out  1  error flag, qualified by rsp_valid_o.
- busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-004 The state machine SHALL have four states, encoded in 2 bits: IDLE, ISSUE, WAIT, RESP.
REQ-005 req_ready_o SHALL equal (state==IDLE), driven from a register.
REQ-006 A request SHALL be accepted on the cycle where req_valid_i && req_ready_o. On acceptance the block captures req_vec_i and req_op_i, and sets chunk_idx=0.
REQ-007 On a legal-op accept:
- ru_sum_o = op[0], ru_max_o = op[1].
- Both are held constant until the cycle after RESP exits.
- Next state is ISSUE.
REQ-008 On an illegal-op accept:
- Next state is RESP with rsp_err_o=1 and rsp_data_o=0.
- ru_start_o never pulses; ru_sum_o and ru_max_o stay 0.
REQ-009 ru_operand_o SHALL equal captured vector bits [chunk_idx*CHUNK_W +: CHUNK_W] in every state, registered.
REQ-010 ISSUE SHALL last exactly one cycle. In it ru_start_o=1, the watchdog clears, and the next state is WAIT.
REQ-011 In WAIT with ru_done_i=1 and chunk_idx<EXEC_CNT-1: chunk_idx increments and the next state is ISSUE. The next start pulse therefore occurs on the cycle after done.
REQ-012 In WAIT with ru_done_i=1 and chunk_idx==EXEC_CNT-1:
- rsp_data_o captures ru_dout_i[OPERAND_WIDTH-1:0] and rsp_err_o=0.
- Next state is RESP, so rsp_valid_o is high on the cycle after the final done.
REQ-013 In WAIT, the watchdog SHALL increment each cycle ru_done_i=0. When it reaches TIMEOUT_CYCLES, the next state is RESP with rsp_err_o=1 and rsp_data_o=0. Done has priority if both events occur in the same cycle.
REQ-014 ru_done_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-015 RESP SHALL hold rsp_valid_o, rsp_data_o and rsp_err_o stable until rsp_ready_i=1, then go to IDLE. A new request cannot be accepted in that same cycle.
REQ-016 Latency with zero stall SHALL be 1 + EXEC_CNT*(1+L) cycles from accept to rsp_valid_o, where L is the cycles from ru_start_o to ru_done_i.
REQ-017 chunk_idx SHALL be $clog2(EXEC_CNT) bits wide and SHALL never wrap within one request.

Reset
REQ-018 While rst_n=0, the block SHALL hold:
- state=IDLE, req_ready_o=1.
- ru_start_o, ru_sum_o, ru_max_o, rsp_valid_o, rsp_err_o, busy_o all 0.
- rsp_data_o, ru_operand_o, chunk_idx, watchdog all 0.
REQ-019 Reset assertion SHALL take effect in any state with no clock required. An in-flight request is dropped without a response, and the first cycle after deassertion accepts requests.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Sum, all 64 elements 0x3F80, model unit L=3 returning 0x4280 -> 4 start pulses with 4-cycle spacing; rsp_data_o=0x4280, rsp_err_o=0, valid 17 cycles after accept.
- Max, element k = k, model returns 0x003F -> chunk i carries elements 16i..16i+15; ru_max_o=1 throughout; rsp_data_o=0x003F.
- rsp_ready_i held low 10 cycles -> rsp_valid_o and rsp_data_o stable; req_ready_o=0; IDLE only after ready.
- Model withholds done, TIMEOUT_CYCLES=8 -> rsp_err_o=1 and rsp_data_o=0 at watchdog=8; then normal next request succeeds.
- req_op_i=2'b11 -> no ru_start_o; rsp_err_o=1 on the cycle after accept.
- rst_n low during WAIT of chunk 2 -> outputs at reset values immediately; no response; a fresh request completes correctly.
